// File: rtl/uvma_dadder_cp_sched.sv
// Round-robin control-plane scheduler for a shared decimal adder/subtracter.
// Grants one requester at a time, pulses en/op for the winner, waits the
// datapath latency, then pulses that requester's response strobe.
module uvma_dadder_cp_sched #(
    parameter  int NUM_REQ = 4,
    parameter  int LATENCY = 2,
    localparam int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_op,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               en,
    output logic               op,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_vld,
    output logic [NUM_REQ-1:0] rsp_valid
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic [SEL_W-1:0]   prio_ptr;
    logic [SEL_W-1:0]   win;
    logic               found;
    logic [NUM_REQ-1:0] sel_oh;
    logic [NUM_REQ-1:0] win_oh;

    // Rotating priority search starting at prio_ptr; the index wraps
    // explicitly so non-power-of-2 NUM_REQ never reaches an unused slot.
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(prio_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx[SEL_W-1:0]]) begin
                found = 1'b1;
                win   = idx[SEL_W-1:0];
            end
        end
    end

    // One-hot forms of the arbitration winner and the current owner.
    always_comb begin
        win_oh = NUM_REQ'(1) << win;
        sel_oh = NUM_REQ'(1) << sel;
    end

    // Ready is only offered from IDLE, and is held low while reset is applied
    // so no handshake can complete in the reset cycle.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && found && !reset) req_ready = win_oh;
    end

    // Scheduler FSM; every control-plane output is registered so en/op move
    // only on the clock edge. The op register doubles as the latched op_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            en        <= 1'b0;
            op        <= 1'b0;
            sel       <= '0;
            sel_vld   <= 1'b0;
            rsp_valid <= '0;
            cnt       <= '0;
            prio_ptr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= ISSUE;
                        sel     <= win;
                        op      <= req_op[win];
                        en      <= 1'b1;
                        sel_vld <= 1'b1;
                    end
                end
                ISSUE: begin
                    en  <= 1'b0;
                    op  <= 1'b0;
                    cnt <= 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state     <= DONE;
                        rsp_valid <= sel_oh;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= DONE;
                        rsp_valid <= sel_oh;
                    end
                end
                DONE: begin
                    rsp_valid <= '0;
                    sel_vld   <= 1'b0;
                    prio_ptr  <= (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uvma_dadder_cp_sched.sv
// Scoreboard bench for uvma_dadder_cp_sched. Four instances cover
// (NUM_REQ,LATENCY) = (4,2), (4,1), (4,15), (3,2); directed stimulus pushes
// expected en/rsp events, a negedge monitor pops and compares them.
module tb_uvma_dadder_cp_sched;

    localparam int ND = 4;

    function automatic int nr_of(int g);
        return (g == 3) ? 3 : 4;
    endfunction

    function automatic int lat_of(int g);
        return (g == 1) ? 1 : ((g == 2) ? 15 : 2);
    endfunction

    typedef struct { int d; int sel; int op; int cyc; } en_exp_t;
    typedef struct { int d; int oh; int cyc; } rsp_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    logic [3:0] rv [ND];
    logic [3:0] rop[ND];
    logic [3:0] rdy[ND];
    logic [3:0] rsp[ND];
    logic       en_a[ND];
    logic       op_a[ND];
    logic       sv_a[ND];
    logic [1:0] sel_a[ND];

    en_exp_t  en_q[$];
    rsp_exp_t rsp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int NR = nr_of(g);
        localparam int L  = lat_of(g);
        logic [NR-1:0] rdy_w;
        logic [NR-1:0] rsp_w;
        uvma_dadder_cp_sched #(.NUM_REQ(NR), .LATENCY(L)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (rv[g][NR-1:0]),
            .req_op    (rop[g][NR-1:0]),
            .req_ready (rdy_w),
            .en        (en_a[g]),
            .op        (op_a[g]),
            .sel       (sel_a[g]),
            .sel_vld   (sv_a[g]),
            .rsp_valid (rsp_w)
        );
        assign rdy[g] = 4'(rdy_w);
        assign rsp[g] = 4'(rsp_w);
    end

    task automatic chk(string name, int act, int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any en or rsp_valid seen must match the head of its queue.
    always @(negedge clk) begin
        en_exp_t  e;
        rsp_exp_t r;
        for (int d = 0; d < ND; d++) begin
            if (en_a[d]) begin
                if (en_q.size() == 0) chk("en_unexpected", d, -1);
                else begin
                    e = en_q.pop_front();
                    chk("en_dut", d, e.d);
                    chk("en_sel", int'(sel_a[d]), e.sel);
                    chk("en_op", int'(op_a[d]), e.op);
                    chk("en_cyc", cyc, e.cyc);
                    chk("en_sel_vld", int'(sv_a[d]), 1);
                end
            end
            if (rsp[d] != 4'd0) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", d, -1);
                else begin
                    r = rsp_q.pop_front();
                    chk("rsp_dut", d, r.d);
                    chk("rsp_onehot", int'(rsp[d]), r.oh);
                    chk("rsp_cyc", cyc, r.cyc);
                    chk("rsp_sel_vld", int'(sv_a[d]), 1);
                end
            end
        end
    end

    // Called at a negedge while DUT d is IDLE: present vec, check the grant,
    // queue the expected en / rsp events, return at the next negedge.
    task automatic accept(int d, logic [3:0] vec, logic [3:0] ops, int win,
                          bit hold, bit exp_rsp);
        rv[d]  = vec;
        rop[d] = ops;
        #1;
        chk("ready", int'(rdy[d]), 1 << win);
        en_q.push_back('{d, win, int'(ops[win]), cyc + 1});
        if (exp_rsp) rsp_q.push_back('{d, 1 << win, cyc + 1 + lat_of(d)});
        @(negedge clk);
        if (!hold) rv[d] = 4'd0;
    endtask

    // Remaining cycles until the DUT is back in IDLE after accept() returns.
    task automatic gap(int d);
        repeat (lat_of(d) + 1) @(negedge clk);
    endtask

    task automatic chk_quiet(int d, string tag);
        chk({tag, "_ready"}, int'(rdy[d]), 0);
        chk({tag, "_en"}, int'(en_a[d]), 0);
        chk({tag, "_op"}, int'(op_a[d]), 0);
        chk({tag, "_sel"}, int'(sel_a[d]), 0);
        chk({tag, "_sel_vld"}, int'(sv_a[d]), 0);
        chk({tag, "_rsp"}, int'(rsp[d]), 0);
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            rv[d]  = 4'b1111;
            rop[d] = 4'd0;
        end
        // Ready stays low while reset is held, even with requests pending.
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) chk("ready_in_reset", int'(rdy[d]), 0);
        for (int d = 0; d < ND; d++) rv[d] = 4'd0;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        for (int d = 0; d < ND; d++) chk_quiet(d, "idle");

        // All four held valid: grants 0,1,2,3,0 every LATENCY+2 cycles.
        for (int k = 0; k < 5; k++) begin
            accept(0, 4'b1111, 4'b1010, k % 4, k < 4, 1'b1);
            gap(0);
        end
        // prio_ptr is now 1: single request 2 (sub) wins, ptr -> 3.
        accept(0, 4'b0100, 4'b0100, 2, 1'b0, 1'b1);
        gap(0);
        // ptr 3 with 1001: 3 first, then wrap to 0.
        accept(0, 4'b1001, 4'b0001, 3, 1'b1, 1'b1);
        gap(0);
        accept(0, 4'b1001, 4'b0001, 0, 1'b0, 1'b1);
        gap(0);

        // LATENCY=1: rsp two cycles after accept.
        accept(1, 4'b0010, 4'b0010, 1, 1'b0, 1'b1);
        gap(1);
        accept(1, 4'b1000, 4'b0000, 3, 1'b0, 1'b1);
        gap(1);

        // LATENCY=15: rsp sixteen cycles after accept.
        accept(2, 4'b0001, 4'b0001, 0, 1'b0, 1'b1);
        gap(2);

        // NUM_REQ=3: grant 2 wraps ptr to 0, then 0 beats 2; then ptr 1.
        accept(3, 4'b0100, 4'b0100, 2, 1'b0, 1'b1);
        gap(3);
        accept(3, 4'b0101, 4'b0001, 0, 1'b0, 1'b1);
        gap(3);
        accept(3, 4'b0110, 4'b0010, 1, 1'b0, 1'b1);
        gap(3);

        // A request raised and dropped while busy is never granted.
        accept(0, 4'b0010, 4'b0000, 1, 1'b0, 1'b1);
        rv[0] = 4'b0100;
        @(negedge clk);
        rv[0] = 4'd0;
        repeat (6) @(negedge clk);

        // Reset in WAIT on the LATENCY=15 instance: no response follows.
        accept(2, 4'b0100, 4'b0100, 2, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_quiet(2, "abort");
        repeat (25) @(negedge clk);

        chk("en_q_drained", en_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
